// File: rtl/cp0_ctrl_param_if.sv
// Pipeline <-> CP0 bundle: MTC0/MFC0 access, exception/ERET/TLB events and the register views.
interface cp0_ctrl_param_if #(
    parameter int TLB_ENTRIES = 16,
    parameter int HW_INTR_NUM = 5
);
    localparam int IDX_W = $clog2(TLB_ENTRIES);

    logic                   pause_i;
    logic                   wen_i;
    logic [4:0]             addr_i;
    logic [31:0]            wdata_i;
    logic [31:0]            rdata_o;
    logic                   exc_valid_i;
    logic [4:0]             exc_code_i;
    logic                   exc_refill_i;
    logic                   exc_bd_i;
    logic [31:0]            exc_pc_i;
    logic [31:0]            exc_badvaddr_i;
    logic                   eret_i;
    logic [HW_INTR_NUM-1:0] hw_intr_i;
    logic                   tlbp_i;
    logic                   tlbp_hit_i;
    logic [IDX_W-1:0]       tlbp_index_i;
    logic                   tlbr_i;
    logic [31:0]            tlbr_entryhi_i;
    logic [31:0]            tlbr_entrylo0_i;
    logic [31:0]            tlbr_entrylo1_i;
    logic                   intr_o;
    logic [31:0]            exc_vector_o;
    logic [31:0]            epc_o;
    logic [31:0]            status_o;
    logic [31:0]            entryhi_o;
    logic [31:0]            entrylo0_o;
    logic [31:0]            entrylo1_o;
    logic [31:0]            index_o;
    logic [31:0]            random_o;

    modport master (
        output pause_i, wen_i, addr_i, wdata_i, exc_valid_i, exc_code_i, exc_refill_i,
               exc_bd_i, exc_pc_i, exc_badvaddr_i, eret_i, hw_intr_i, tlbp_i, tlbp_hit_i,
               tlbp_index_i, tlbr_i, tlbr_entryhi_i, tlbr_entrylo0_i, tlbr_entrylo1_i,
        input  rdata_o, intr_o, exc_vector_o, epc_o, status_o, entryhi_o, entrylo0_o,
               entrylo1_o, index_o, random_o
    );

    modport slave (
        input  pause_i, wen_i, addr_i, wdata_i, exc_valid_i, exc_code_i, exc_refill_i,
               exc_bd_i, exc_pc_i, exc_badvaddr_i, eret_i, hw_intr_i, tlbp_i, tlbp_hit_i,
               tlbp_index_i, tlbr_i, tlbr_entryhi_i, tlbr_entrylo0_i, tlbr_entrylo1_i,
        output rdata_o, intr_o, exc_vector_o, epc_o, status_o, entryhi_o, entrylo0_o,
               entrylo1_o, index_o, random_o
    );
endinterface

// File: rtl/cp0_ctrl_param.sv
// CP0 register file and exception controller (TLB regs, Status/Cause/EPC/BadVAddr, Random).
// Define CP0_COUNT_COMPARE_EN to build the Count/Compare timer that drives IP[7].
module cp0_ctrl_param #(
    parameter int TLB_ENTRIES = 16,
    parameter int HW_INTR_NUM = 5,
    parameter int COUNT_DIV   = 2
) (
    input logic             clk,
    input logic             reset,
    cp0_ctrl_param_if.slave bus
);
    localparam int IDX_W = $clog2(TLB_ENTRIES);
    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

    logic             idx_p_q;
    logic [IDX_W-1:0] idx_q, random_q, wired_q;
    logic [25:0]      entrylo0_q, entrylo1_q;
    logic [18:0]      vpn2_q;
    logic [7:0]       asid_q;
    logic [31:0]      badvaddr_q, epc_q;
    logic [7:0]       im_q;
    logic             um_q, exl_q, ie_q;
    logic             bd_q;
    logic [1:0]       ip_sw_q;
    logic [4:0]       exc_code_q;
    logic [31:0]      count_rd, compare_rd;
    logic             timer_pend;
    logic [7:0]       ip;
    logic [31:0]      status_rd, cause_rd, entryhi_rd, index_rd, random_rd, wired_rd;
    logic             do_exc, do_eret, do_tlbp, do_tlbr, do_mtc0;
    logic             wr_wired, vaddr_exc, tlb_exc;
    logic             unused_bits;

    // One event per cycle; anything below the winner is discarded entirely.
    always_comb begin
        do_exc  = !bus.pause_i && bus.exc_valid_i;
        do_eret = !bus.pause_i && !bus.exc_valid_i && bus.eret_i;
        do_tlbp = !bus.pause_i && !bus.exc_valid_i && !bus.eret_i && bus.tlbp_i;
        do_tlbr = !bus.pause_i && !bus.exc_valid_i && !bus.eret_i && bus.tlbr_i;
        do_mtc0 = !bus.pause_i && !bus.exc_valid_i && !bus.eret_i &&
                  !bus.tlbp_i && !bus.tlbr_i && bus.wen_i;
    end

    assign wr_wired  = do_mtc0 && (bus.addr_i == 5'd6);
    assign vaddr_exc = (bus.exc_code_i >= 5'd1) && (bus.exc_code_i <= 5'd5);
    assign tlb_exc   = (bus.exc_code_i >= 5'd1) && (bus.exc_code_i <= 5'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_p_q    <= 1'b0;
            idx_q      <= '0;
            random_q   <= RAND_TOP;
            wired_q    <= '0;
            entrylo0_q <= '0;
            entrylo1_q <= '0;
            vpn2_q     <= '0;
            asid_q     <= '0;
            badvaddr_q <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            um_q       <= 1'b0;
            exl_q      <= 1'b1;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_sw_q    <= '0;
            exc_code_q <= '0;
        end else begin
            if (do_exc) begin
                // A nested exception keeps the original return point.
                if (!exl_q) begin
                    epc_q <= bus.exc_bd_i ? bus.exc_pc_i - 32'd4 : bus.exc_pc_i;
                    bd_q  <= bus.exc_bd_i;
                end
                exc_code_q <= bus.exc_code_i;
                exl_q      <= 1'b1;
                if (vaddr_exc) badvaddr_q <= bus.exc_badvaddr_i;
                if (tlb_exc)   vpn2_q     <= bus.exc_badvaddr_i[31:13];
            end
            if (do_eret) exl_q <= 1'b0;
            if (do_tlbp) begin
                idx_p_q <= !bus.tlbp_hit_i;
                if (bus.tlbp_hit_i) idx_q <= bus.tlbp_index_i;
            end
            if (do_tlbr) begin
                vpn2_q     <= bus.tlbr_entryhi_i[31:13];
                asid_q     <= bus.tlbr_entryhi_i[7:0];
                entrylo0_q <= bus.tlbr_entrylo0_i[25:0];
                entrylo1_q <= bus.tlbr_entrylo1_i[25:0];
            end
            if (do_mtc0) begin
                case (bus.addr_i)
                    5'd0:  idx_q      <= bus.wdata_i[IDX_W-1:0];
                    5'd2:  entrylo0_q <= bus.wdata_i[25:0];
                    5'd3:  entrylo1_q <= bus.wdata_i[25:0];
                    5'd6:  wired_q    <= bus.wdata_i[IDX_W-1:0];
                    5'd10: begin
                        vpn2_q <= bus.wdata_i[31:13];
                        asid_q <= bus.wdata_i[7:0];
                    end
                    5'd12: begin
                        im_q  <= bus.wdata_i[15:8];
                        um_q  <= bus.wdata_i[4];
                        exl_q <= bus.wdata_i[1];
                        ie_q  <= bus.wdata_i[0];
                    end
                    5'd13: ip_sw_q <= bus.wdata_i[9:8];
                    5'd14: epc_q   <= bus.wdata_i;
                    default: ;
                endcase
            end
            if (!bus.pause_i) begin
                if (wr_wired || (random_q <= wired_q) || (wired_q >= RAND_TOP))
                    random_q <= RAND_TOP;
                else
                    random_q <= random_q - IDX_W'(1);
            end
        end
    end

`ifdef CP0_COUNT_COMPARE_EN
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [31:0]      count_q, compare_q;
    logic             pend_q, tick, wr_count, wr_compare;

    assign tick       = (div_q == DIV_W'(COUNT_DIV - 1));
    assign wr_count   = do_mtc0 && (bus.addr_i == 5'd9);
    assign wr_compare = do_mtc0 && (bus.addr_i == 5'd11);

    // The timer keeps running through pipeline stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            if (wr_count) begin
                count_q <= bus.wdata_i;
                div_q   <= '0;
            end else if (tick) begin
                count_q <= count_q + 32'd1;
                div_q   <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
            if (wr_compare) begin
                compare_q <= bus.wdata_i;
                pend_q    <= 1'b0;
            end else if (tick && !wr_count && (count_q + 32'd1 == compare_q)) begin
                pend_q <= 1'b1;
            end
        end
    end

    assign count_rd   = count_q;
    assign compare_rd = compare_q;
    assign timer_pend = pend_q;
`else
    assign count_rd   = '0;
    assign compare_rd = '0;
    assign timer_pend = 1'b0;
`endif

    always_comb begin
        ip                   = '0;
        ip[1:0]              = ip_sw_q;
        ip[2 +: HW_INTR_NUM] = bus.hw_intr_i;
        ip[7]                = timer_pend;
    end

    assign status_rd  = {16'b0, im_q, 3'b0, um_q, 2'b0, exl_q, ie_q};
    assign cause_rd   = {bd_q, 15'b0, ip, 1'b0, exc_code_q, 2'b0};
    assign entryhi_rd = {vpn2_q, 5'b0, asid_q};
    assign index_rd   = {idx_p_q, {(31 - IDX_W){1'b0}}, idx_q};
    assign random_rd  = {{(32 - IDX_W){1'b0}}, random_q};
    assign wired_rd   = {{(32 - IDX_W){1'b0}}, wired_q};

    always_comb begin
        bus.rdata_o = '0;
        case (bus.addr_i)
            5'd0:  bus.rdata_o = index_rd;
            5'd1:  bus.rdata_o = random_rd;
            5'd2:  bus.rdata_o = {6'b0, entrylo0_q};
            5'd3:  bus.rdata_o = {6'b0, entrylo1_q};
            5'd6:  bus.rdata_o = wired_rd;
            5'd8:  bus.rdata_o = badvaddr_q;
            5'd9:  bus.rdata_o = count_rd;
            5'd10: bus.rdata_o = entryhi_rd;
            5'd11: bus.rdata_o = compare_rd;
            5'd12: bus.rdata_o = status_rd;
            5'd13: bus.rdata_o = cause_rd;
            5'd14: bus.rdata_o = epc_q;
            5'd16: bus.rdata_o = 32'h8000_0082;
            default: bus.rdata_o = '0;
        endcase
    end

    assign bus.intr_o       = (|(ip & im_q)) && ie_q && !exl_q;
    assign bus.exc_vector_o = (bus.exc_refill_i && !exl_q) ? 32'h8000_0000 : 32'h8000_0180;
    assign bus.epc_o        = epc_q;
    assign bus.status_o     = status_rd;
    assign bus.entryhi_o    = entryhi_rd;
    assign bus.entrylo0_o   = {6'b0, entrylo0_q};
    assign bus.entrylo1_o   = {6'b0, entrylo1_q};
    assign bus.index_o      = index_rd;
    assign bus.random_o     = random_rd;

    assign unused_bits = ^{bus.wdata_i, bus.tlbr_entryhi_i, bus.tlbr_entrylo0_i,
                           bus.tlbr_entrylo1_i, bus.exc_badvaddr_i};
endmodule
